// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the issue-side register scoreboard: counter width,
// latency classes and the operand hazard helper.
package reg_scoreboard_pkg;

    localparam int SB_LAT_W  = 6;
    localparam int SB_NREG   = 32;
    localparam int SB_ADDR_W = 5;

    // Cycles until a producer's result reaches a forwarding point.
    localparam logic [SB_LAT_W-1:0] LAT_ALU  = 6'd0;
    localparam logic [SB_LAT_W-1:0] LAT_LOAD = 6'd1;
    localparam logic [SB_LAT_W-1:0] LAT_MUL  = 6'd3;
    localparam logic [SB_LAT_W-1:0] LAT_DIV  = 6'd5;

    typedef struct packed {
        logic raw1;
        logic raw2;
        logic waw;
    } hazard_t;

    // A register access is blocked when it is enabled, is not r0, and the
    // register still has a producer that cannot be forwarded yet.
    function automatic logic reg_pending(input logic                 en,
                                         input logic [SB_ADDR_W-1:0] addr,
                                         input logic                 busy_bit);
        return en && (addr != 5'd0) && busy_bit;
    endfunction

endpackage

// File: rtl/reg_scoreboard_slot.sv
// One scoreboard slot: a latency countdown that loads from zero, counts down
// to zero and freezes while the pipeline is held.
module sb_slot
    import reg_scoreboard_pkg::*;
#(
    parameter int LAT_W = SB_LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [LAT_W-1:0] ld_val,
    input  logic             hold,
    output logic             busy
);

    logic [LAT_W-1:0] cnt_r;

    // Countdown: reset beats hold, hold beats load, load beats decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {LAT_W{1'b0}};
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (ld) begin
            cnt_r <= ld_val;
        end else if (cnt_r != {LAT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = (cnt_r != {LAT_W{1'b0}});

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard controller. Tracks GPRs whose producers (loads, mul/div)
// are not yet forwardable and requests a stall until every operand of the
// instruction in ID can be forwarded.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int LAT_W = SB_LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_re1,
    input  logic [4:0]       id_raddr1,
    input  logic             id_re2,
    input  logic [4:0]       id_raddr2,
    input  logic             id_we,
    input  logic [4:0]       id_waddr,
    input  logic [LAT_W-1:0] id_lat,
    output logic             stall_req,
    output logic [NREG-1:0]  busy_vec,
    output logic             issue
);

    logic [NREG-1:0] busy_s;
    hazard_t         haz_s;
    logic            stall_s;
    logic            issue_s;
    logic            load_s;

    // r0 is hard-wired and never has a pending producer.
    assign busy_s[0] = 1'b0;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_slot
            logic ld_s;
            assign ld_s = load_s && (id_waddr == 5'(r));

            sb_slot #(
                .LAT_W (LAT_W)
            ) u_slot (
                .clk    (clk),
                .rst    (rst),
                .ld     (ld_s),
                .ld_val (id_lat),
                .hold   (ext_stall),
                .busy   (busy_s[r])
            );
        end
    endgenerate

    // Hazard detection and issue decision; stall is independent of ext_stall
    // so pipeline control sees the scoreboard's own view every cycle.
    always_comb begin
        haz_s.raw1 = reg_pending(id_re1, id_raddr1, busy_s[id_raddr1]);
        haz_s.raw2 = reg_pending(id_re2, id_raddr2, busy_s[id_raddr2]);
        haz_s.waw  = reg_pending(id_we,  id_waddr,  busy_s[id_waddr]);
        if (id_valid && !flush) begin
            stall_s = |haz_s;
            issue_s = !ext_stall && !stall_s;
        end else begin
            stall_s = 1'b0;
            issue_s = 1'b0;
        end
        // ALU-class results (latency 0) rely purely on forwarding.
        load_s = issue_s && id_we && (id_waddr != 5'd0) && (id_lat != {LAT_W{1'b0}});
    end

    assign stall_req = stall_s;
    assign issue     = issue_s;
    assign busy_vec  = busy_s;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: hand-derived vector table for the
// corner sequences, then randomized traffic against a remaining-cycles model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ext_stall, flush, id_valid;
    logic        id_re1, id_re2, id_we;
    logic [4:0]  id_raddr1, id_raddr2, id_waddr;
    logic [5:0]  id_lat;
    logic        stall_req, issue;
    logic [31:0] busy_vec;

    reg_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .ext_stall (ext_stall),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_re1    (id_re1),
        .id_raddr1 (id_raddr1),
        .id_re2    (id_re2),
        .id_raddr2 (id_raddr2),
        .id_we     (id_we),
        .id_waddr  (id_waddr),
        .id_lat    (id_lat),
        .stall_req (stall_req),
        .busy_vec  (busy_vec),
        .issue     (issue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ext, fl, v, re1;
        logic [4:0]  a1;
        logic        re2;
        logic [4:0]  a2;
        logic        we;
        logic [4:0]  wa;
        logic [5:0]  lat;
        logic        es, ei;
        logic [31:0] eb;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int m_cnt [32];   // cycles until each register becomes forwardable
    vec_t tbl [$];

    function automatic vec_t mk(logic r, logic e, logic f, logic v, logic re1, logic [4:0] a1,
                                logic re2, logic [4:0] a2, logic we, logic [4:0] wa,
                                logic [5:0] lat, logic es, logic ei, logic [31:0] eb);
        vec_t t;
        t.rst = r; t.ext = e; t.fl = f; t.v = v; t.re1 = re1; t.a1 = a1;
        t.re2 = re2; t.a2 = a2; t.we = we; t.wa = wa; t.lat = lat;
        t.es = es; t.ei = ei; t.eb = eb;
        return t;
    endfunction

    function automatic logic [31:0] bv(int r);
        return 32'd1 << r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic m_pend(logic en, logic [4:0] a);
        return en && (a != 5'd0) && (m_cnt[a] > 0);
    endfunction

    // Drive one cycle, compare against the model (and the table row when
    // use_tbl is set), then advance the model across the clock edge.
    task automatic run(vec_t t, bit use_tbl, string tag);
        logic        e_stall, e_issue;
        logic [31:0] e_busy;
        rst = t.rst; ext_stall = t.ext; flush = t.fl; id_valid = t.v;
        id_re1 = t.re1; id_raddr1 = t.a1; id_re2 = t.re2; id_raddr2 = t.a2;
        id_we = t.we; id_waddr = t.wa; id_lat = t.lat;
        @(negedge clk);
        e_stall = t.v && !t.fl &&
                  (m_pend(t.re1, t.a1) || m_pend(t.re2, t.a2) || m_pend(t.we, t.wa));
        e_issue = t.v && !t.fl && !t.ext && !e_stall;
        e_busy  = 32'd0;
        for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) e_busy[i] = 1'b1;
        check({tag, " stall_req(model)"}, 32'(stall_req), 32'(e_stall));
        check({tag, " issue(model)"},     32'(issue),     32'(e_issue));
        check({tag, " busy_vec(model)"},  busy_vec,       e_busy);
        if (use_tbl) begin
            check({tag, " stall_req"}, 32'(stall_req), 32'(t.es));
            check({tag, " issue"},     32'(issue),     32'(t.ei));
            check({tag, " busy_vec"},  busy_vec,       t.eb);
        end
        @(posedge clk);
        if (t.rst) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else if (!t.ext) begin
            for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            if (e_issue && t.we && t.wa != 5'd0 && t.lat != 6'd0) m_cnt[t.wa] = int'(t.lat);
        end
        #1;
    endtask

    initial begin
        vec_t t;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        rst = 1'b1; ext_stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_re1 = 1'b0; id_raddr1 = 5'd0; id_re2 = 1'b0; id_raddr2 = 5'd0;
        id_we = 1'b0; id_waddr = 5'd0; id_lat = 6'd0;

        //          rst  ext  fl   v    re1  a1    re2  a2    we   wa    lat       st   is   busy
        // reset with a reader of $5 present, then lw $5 and reset again
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b1,5'd5, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b1,5'd5, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd5, LAT_LOAD,1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b0,1'b0,bv(5)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b0,1'b0,32'd0));
        // load-use: lw $8, addu $9,$8,$0 stalls one cycle
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd1, 1'b0,5'd0, 1'b1,5'd8, LAT_LOAD,1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd8, 1'b1,5'd0, 1'b1,5'd9, LAT_ALU, 1'b1,1'b0,bv(8)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd8, 1'b1,5'd0, 1'b1,5'd9, LAT_ALU, 1'b0,1'b1,32'd0));
        // independent reader of $10 right after lw $8
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd1, 1'b0,5'd0, 1'b1,5'd8, LAT_LOAD,1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd10,1'b0,5'd0, 1'b1,5'd11,LAT_ALU, 1'b0,1'b1,bv(8)));
        // div $12 lat 5, reader waits 5 cycles plus 3 frozen cycles
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd2, 1'b1,5'd3, 1'b1,5'd12,LAT_DIV, 1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd12,1'b0,5'd0, 1'b1,5'd13,LAT_ALU, 1'b1,1'b0,bv(12)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd12,1'b0,5'd0, 1'b1,5'd13,LAT_ALU, 1'b1,1'b0,bv(12)));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,1'b1,5'd12,1'b0,5'd0,1'b1,5'd13,LAT_ALU,1'b1,1'b0,bv(12)));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd12,1'b0,5'd0,1'b1,5'd13,LAT_ALU,1'b1,1'b0,bv(12)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd12,1'b0,5'd0, 1'b1,5'd13,LAT_ALU, 1'b0,1'b1,32'd0));
        // WAW: div $12 lat 4, then lw $12 waits 4 cycles, then loads 1
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd2, 1'b1,5'd3, 1'b1,5'd12,6'd4,    1'b0,1'b1,32'd0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd2,1'b0,5'd0,1'b1,5'd12,LAT_LOAD,1'b1,1'b0,bv(12)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd2, 1'b0,5'd0, 1'b1,5'd12,LAT_LOAD,1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b0,1'b0,bv(12)));
        // r0: lw $0 is not tracked, readers of $0 never stall
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd1, 1'b0,5'd0, 1'b1,5'd0, LAT_LOAD,1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd0, 1'b1,5'd0, 1'b1,5'd14,LAT_ALU, 1'b0,1'b1,32'd0));
        // flush: counter of $8 keeps decrementing under a flushed reader
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd1, 1'b0,5'd0, 1'b1,5'd8, LAT_MUL, 1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b1,5'd8, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b0,1'b0,bv(8)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd8, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b1,1'b0,bv(8)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd8, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b1,1'b0,bv(8)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd8, 1'b0,5'd0, 1'b0,5'd0, 6'd0,    1'b0,1'b1,32'd0));
        // dual operands: cnt[3]=2, cnt[4]=1, reader of $3,$4
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd1, 1'b1,5'd2, 1'b1,5'd3, LAT_MUL, 1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd5, 1'b0,5'd0, 1'b1,5'd4, LAT_LOAD,1'b0,1'b1,bv(3)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd3, 1'b1,5'd4, 1'b1,5'd6, LAT_ALU, 1'b1,1'b0,bv(3)|bv(4)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd3, 1'b1,5'd4, 1'b1,5'd6, LAT_ALU, 1'b1,1'b0,bv(3)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd3, 1'b1,5'd4, 1'b1,5'd6, LAT_ALU, 1'b0,1'b1,32'd0));
        // same register on both operands
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd1, 1'b0,5'd0, 1'b1,5'd7, LAT_LOAD,1'b0,1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd7, 1'b1,5'd7, 1'b1,5'd9, LAT_ALU, 1'b1,1'b0,bv(7)));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,5'd7, 1'b1,5'd7, 1'b1,5'd9, LAT_ALU, 1'b0,1'b1,32'd0));

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], 1'b1, $sformatf("row%0d", i));

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            t = mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,6'd0,1'b0,1'b0,32'd0);
            t.rst = ($urandom_range(0, 199) == 0);
            t.ext = ($urandom_range(0, 5) == 0);
            t.fl  = ($urandom_range(0, 7) == 0);
            t.v   = ($urandom_range(0, 3) != 0);
            t.re1 = 1'($urandom_range(0, 1));
            t.re2 = 1'($urandom_range(0, 1));
            t.we  = 1'($urandom_range(0, 1));
            t.a1  = 5'($urandom_range(0, 9));
            t.a2  = 5'($urandom_range(0, 9));
            t.wa  = 5'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) t.wa = 5'($urandom_range(0, 31));
            t.lat = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(8, 63))
                                                : 6'($urandom_range(0, 6));
            run(t, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side hazard controller for the 5-stage pipeline; sits beside the register file at ID.
- Forwarding from EX/MEM/WB covers single-cycle producers. This block tracks registers whose producers are not yet forwardable (loads, multi-cycle mul/div) with per-register countdowns.
- Raises a stall request to the pipeline control block until every operand of the ID instruction can be forwarded.

Parameters:
- NREG, 32, number of GPRs; r0 is never tracked.
- LAT_W, 6, width of each per-register latency counter; max latency 2^LAT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ext_stall  in  1  pipeline frozen by another source; counters hold, no issue
- flush  in  1  ID instruction killed this cycle; no issue
- id_valid  in  1  ID holds a valid instruction
- id_re1  in  1  operand 1 is read
- id_raddr1  in  5  operand 1 register
- id_re2  in  1  operand 2 is read
- id_raddr2  in  5  operand 2 register
- id_we  in  1  instruction writes a GPR
- id_waddr  in  5  destination register
- id_lat  in  LAT_W  cycles until result is forwardable; 0 = ALU class, 1 = load, larger = mul/div
- stall_req  out  1  hold IF/ID and insert bubble into EX
- busy_vec  out  NREG  bit r set when cnt[r] != 0; bit 0 always 0
- issue  out  1  instruction accepted this cycle

Behaviour:
- State: cnt[1..NREG-1], each LAT_W bits. Reset value is 0 for all counters. After reset, stall_req=0, issue=0 and busy_vec=0.
- Hazard terms (combinational):
  - raw1 = id_re1 && raddr1!=0 && cnt[raddr1]!=0
  - raw2 = the same term for operand 2
  - waw = id_we && waddr!=0 && cnt[waddr]!=0
- stall_req = id_valid && !flush && (raw1 || raw2 || waw). It has zero latency and is independent of ext_stall.
- issue = id_valid && !flush && !ext_stall && !stall_req.
- Per-cycle update when ext_stall=0:
  - Every nonzero cnt decrements by 1, saturating at 0.
  - Then, if issue && id_we && waddr!=0 && id_lat!=0, cnt[waddr] is loaded with id_lat. The load wins over the decrement. The WAW check guarantees the slot was already 0.
- When ext_stall=1, all counters hold. A stalled producer is not advancing, so its latency must not elapse.
- When rst=1, all counters clear in the same cycle, overriding issue, decrement and ext_stall.
- Semantics: cnt[r]=k means the value becomes forwardable k cycles from now. Example: a load issued at cycle t with lat=1 blocks a dependent instruction at t+1; that instruction issues at t+2, the load-use bubble.
- Writes to r0 are never tracked. Reads of r0 never stall.
- raddr1 == raddr2 is handled naturally and gives a single condition.
- id_lat=0 leaves cnt unchanged, so ALU ops rely purely on forwarding.
- flush=1 suppresses stall_req and issue. Counters of older in-flight producers keep decrementing; flush never clears them.
- Counter wrap is impossible: loads only happen from 0, and values only decrement.

Decomposition:
- Add to the shared defines header:
  - SB_LAT_W
  - latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL, LAT_DIV
- One natural sub-module: sb_slot.
  - Holds one counter with load/decrement/hold/reset.
  - Inputs: ld, ld_val, hold.
  - Output: busy.
  - Instantiated NREG-1 times in a generate loop.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1, raddr1=5 → stall_req=0, busy_vec=0. Issue lw $5 (lat 1), then hold rst → busy_vec clears next cycle.
- Load-use:
  - Stimulus: lw $8 (lat=1) issued at t, then addu $9,$8,$0 held at ID.
  - Required: stall_req=1 at t+1, 0 at t+2; issue=1 at t+2.
  - Negative case: an independent reader of $10 at t+1 → no stall.
- Divide latency with freeze:
  - Stimulus: issue div writer $12 with lat=5, a reader of $12 waiting, ext_stall=1 for 3 cycles mid-countdown.
  - Required: stall_req stays 1 for 5+3=8 cycles; busy_vec[12] clears exactly when the counter reaches 0.
- WAW and r0:
  - Stimulus: div $12 lat=4 in flight; lw writes $12.
  - Required: stall until cnt[12]=0, then issue and cnt[12]=1.
  - Also: issue lw $0 → busy_vec=0, and a later reader of $0 never stalls.
- Flush: reader of busy $8 with flush=1 → stall_req=0, issue=0; cnt[8] still decrements.
- Dual operands: cnt[3]=2, cnt[4]=1, reader of $3,$4 → stall 2 cycles, issue on the third.
